ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver_pkg.sv | 32 +++
 rtl/ssd_scan_timer.sv | 33 +++
 rtl/ssd_scan_driver.sv | 140 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants, scan FSM states and the leading-zero helper for the scan driver.
// Pure declarations: no latency and no backpressure, nothing here is clocked.
// The helper works on an 8-digit view; callers zero-extend narrower displays.
package ssd_scan_driver_pkg;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int SCAN_DIV_DEF   = 50000;
  localparam int BLANK_CYC_DEF  = 64;
  localparam int MAX_DIGITS     = 8;

  // Active-low common enables, so "all digits off" is all ones.
  localparam logic [MAX_DIGITS-1:0] DIGIT_ALL_OFF = '1;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  // Digit pos is a leading zero when it and every higher digit shows 0 with no dash.
  // Digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lz_hidden(input logic [4*MAX_DIGITS-1:0] val,
                                     input logic [MAX_DIGITS-1:0]   dash,
                                     input int                      pos);
    logic hide;
    hide = (pos != 0);
    for (int j = 0; j < MAX_DIGITS; j++) begin
      if (j >= pos && (val[4*j +: 4] != 4'h0 || dash[j])) hide = 1'b0;
    end
    return hide;
  endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Per-digit slot counter: counts 0..SCAN_DIV-1, flags the wrap cycle and the dead time.
// Flags are combinational from the count register, so there is no added latency.
// There is no backpressure: holding run low clears the count and keeps it at 0.
module ssd_scan_timer #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic slot_wrap,
  output logic in_blank
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || cnt_q == LAST_CNT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign slot_wrap = run && (cnt_q == LAST_CNT);
  assign in_blank  = (int'(cnt_q) < BLANK_CYC);

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: it cycles through the digits and hands the nibble and dash flag to the decoder.
// Latency: digit data is registered at each slot start; the enables follow after BLANK_CYC cycles of dead time.
// There is no backpressure: a load is always accepted into pending, and the newest load replaces an older one.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF,
  parameter int BLANK_CYC  = BLANK_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dash_mask,
  input  logic                    blank_lz,
  output logic [3:0]              digit_bits,
  output logic                    digit_dash,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic                    start;
  logic                    run;
  logic                    slot_wrap;
  logic                    in_blank;
  logic                    frame_d;
  logic                    upd;
  logic [IW-1:0]           idx_q, idx_nxt;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val, nxt_val;
  logic [NUM_DIGITS-1:0]   pend_dash, act_dash, nxt_dash;
  logic [3:0]              bits_q;
  logic                    dash_q;
  logic                    lz_q;
  logic                    frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The first enabled cycle starts a frame with the counter still at 0.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SCAN;
          start   = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run = enable && (state_q == ST_SCAN);

  ssd_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .slot_wrap (slot_wrap),
    .in_blank  (in_blank)
  );

  assign frame_d = start || (slot_wrap && idx_q == LAST_IDX);
  assign upd     = start || slot_wrap;

  always_comb begin
    idx_nxt = idx_q;
    if (start)          idx_nxt = '0;
    else if (slot_wrap) idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       idx_q <= '0;
    else if (!enable) idx_q <= '0;
    else              idx_q <= idx_nxt;
  end

  // Active takes the pending value from before this cycle's load, so a load on the wrap edge waits one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dash <= '0;
      act_val   <= '0;
      act_dash  <= '0;
    end else begin
      if (load) begin
        pend_val  <= value;
        pend_dash <= dash_mask;
      end
      if (frame_d) begin
        act_val  <= pend_val;
        act_dash <= pend_dash;
      end
    end
  end

  assign nxt_val  = frame_d ? pend_val  : act_val;
  assign nxt_dash = frame_d ? pend_dash : act_dash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q  <= '0;
      dash_q  <= 1'b0;
      lz_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      if (upd) begin
        dash_q <= nxt_dash[idx_nxt];
        bits_q <= nxt_dash[idx_nxt] ? 4'h0 : nxt_val[{idx_nxt, 2'b00} +: 4];
        lz_q   <= lz_hidden(32'(nxt_val), 8'(nxt_dash), int'(idx_nxt));
      end
    end
  end

  assign digit_bits  = bits_q;
  assign digit_dash  = dash_q;
  assign frame_start = frame_q;

  // Dropping enable or reset blanks the display without waiting for a clock edge.
  assign digit_en_n = (!run || in_blank || (blank_lz && lz_q))
                    ? DIGIT_ALL_OFF[NUM_DIGITS-1:0]
                    : ~(NUM_DIGITS'(1) << idx_q);

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomised bench for ssd_scan_driver that checks the DUT against a time-based reference model.
module tb_ssd_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRM = ND * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dash_mask;
  logic          blank_lz;
  logic [3:0]    digit_bits;
  logic          digit_dash;
  logic [3:0]    digit_en_n;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  // Model state: the time since scanning (re)started gives the slot, the position in the slot and the frame edges.
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdash, m_adash;
  bit          m_run;
  int          m_t;
  bit          m_frame;
  logic [3:0]  e_en, e_bits;
  logic        e_dash, e_frame;
  bit          e_chk;

  always #5 clk = ~clk;

  ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dash_mask(dash_mask), .blank_lz(blank_lz), .digit_bits(digit_bits),
    .digit_dash(digit_dash), .digit_en_n(digit_en_n), .frame_start(frame_start)
  );

  task automatic model_clear();
    m_pend = '0; m_act = '0; m_pdash = '0; m_adash = '0; m_run = 0; m_t = 0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then compute the expected outputs.
  task automatic step();
    int  slot, pos;
    bit  hide;
    @(posedge clk);
    m_frame = 0;
    if (!rst_n) model_clear();
    else if (!enable) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; m_frame = 1; end
    else begin m_t++; m_frame = (m_t % FRM == 0); end
    if (rst_n && m_frame) begin m_act = m_pend; m_adash = m_pdash; end
    if (rst_n && load) begin m_pend = value; m_pdash = dash_mask; end
    slot = (m_t / DIV) % ND;
    pos  = m_t % DIV;
    hide = blank_lz && slot != 0 && ((m_act >> (4 * slot)) == 0) && ((m_adash >> slot) == 0);
    e_en    = (!rst_n || !enable || !m_run || pos < BLK || hide) ? 4'hF : ~(4'b0001 << slot);
    e_frame = m_frame;
    e_dash  = m_adash[slot];
    e_bits  = e_dash ? 4'h0 : m_act[4*slot +: 4];
    e_chk   = m_run;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; load = 0; value = '0; dash_mask = '0; blank_lz = 0;
    model_clear();
    #1;
    total++; if (digit_en_n !== 4'hF) begin bad++; $display("FAIL reset_en got=%b exp=1111", digit_en_n); end
    total++; if ({digit_bits, digit_dash, frame_start} !== 6'b0) begin bad++;
      $display("FAIL reset_out got=%h/%b/%b exp=0/0/0", digit_bits, digit_dash, frame_start); end
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin @(negedge clk); rst_n = 1; end
      step();
      total++; if ({digit_en_n, frame_start} !== {e_en, e_frame}) begin bad++;
        $display("FAIL reset_idle i=%0d got=%b/%b exp=%b/%b", i, digit_en_n, frame_start, e_en, e_frame); end
    end
  endtask

  task automatic test_basic();
    logic [3:0] seq_en [4];
    logic [3:0] seq_bits [4];
    int lows, fs_wait;
    seq_en = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seq_bits = '{4'h4, 4'h3, 4'h2, 4'h1};
    lows = 0;
    value = 16'h1234; dash_mask = '0; load = 1;
    step(); load = 0; enable = 1;
    fs_wait = 0;
    while (frame_start !== 1'b1 && fs_wait < 4) begin step(); fs_wait++; end
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL basic_fs_timeout got=%b exp=1", frame_start); end
    for (int i = 0; i < 2 * FRM; i++) begin
      step();
      total++; if ({digit_en_n, frame_start} !== {e_en, e_frame}) begin bad++;
        $display("FAIL basic_en t=%0d got=%b/%b exp=%b/%b", m_t, digit_en_n, frame_start, e_en, e_frame); end
      if (e_chk) begin total++; if ({digit_dash, digit_bits} !== {e_dash, e_bits}) begin bad++;
        $display("FAIL basic_bits t=%0d got=%b/%h exp=%b/%h", m_t, digit_dash, digit_bits, e_dash, e_bits); end end
      if (m_t >= FRM && m_t < 2 * FRM) begin
        if (digit_en_n != 4'hF) lows++;
        if (m_t % DIV == BLK) begin
          total++; if ({digit_en_n, digit_bits} !== {seq_en[(m_t / DIV) % ND], seq_bits[(m_t / DIV) % ND]}) begin bad++;
            $display("FAIL basic_seq t=%0d got=%b/%h exp=%b/%h", m_t, digit_en_n, digit_bits,
                     seq_en[(m_t / DIV) % ND], seq_bits[(m_t / DIV) % ND]); end
        end
      end
    end
    total++; if (lows !== 24) begin bad++; $display("FAIL basic_duty got=%0d exp=24", lows); end
  endtask

  // Runs a fixed number of cycles with full model checks, optionally loading on the first cycle.
  task automatic run_checked(input string name, input int cycles, input bit do_load,
                             input logic [15:0] v, input logic [3:0] d);
    if (do_load) begin value = v; dash_mask = d; load = 1; end
    for (int i = 0; i < cycles; i++) begin
      step(); load = 0;
      total++; if ({digit_en_n, frame_start} !== {e_en, e_frame}) begin bad++;
        $display("FAIL %s_en t=%0d got=%b/%b exp=%b/%b", name, m_t, digit_en_n, frame_start, e_en, e_frame); end
      if (e_chk) begin total++; if ({digit_dash, digit_bits} !== {e_dash, e_bits}) begin bad++;
        $display("FAIL %s_bits t=%0d got=%b/%h exp=%b/%h", name, m_t, digit_dash, digit_bits, e_dash, e_bits); end end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < 2 * FRM && m_t % FRM != 2 * DIV; i++) step();
    total++; if (digit_bits !== 4'h2) begin bad++; $display("FAIL mid_pre got=%h exp=2", digit_bits); end
    run_checked("mid", 2 * FRM, 1, 16'hABCD, 4'b0000);
  endtask

  task automatic test_lz();
    int hi_low;
    blank_lz = 1;
    run_checked("lz", FRM + 4, 1, 16'h0005, 4'b0000);
    hi_low = 0;
    for (int i = 0; i < FRM; i++) begin
      step();
      if (digit_en_n[3:1] != 3'b111) hi_low++;
      total++; if ({digit_en_n, digit_bits} !== {e_en, e_bits}) begin bad++;
        $display("FAIL lz_on t=%0d got=%b/%h exp=%b/%h", m_t, digit_en_n, digit_bits, e_en, e_bits); end
    end
    total++; if (hi_low !== 0) begin bad++; $display("FAIL lz_hidden got=%0d exp=0", hi_low); end
    blank_lz = 0;
    run_checked("lz_off", FRM, 0, '0, '0);
  endtask

  task automatic test_dash();
    blank_lz = 1;
    run_checked("dash", 2 * FRM + 4, 1, 16'h0000, 4'b1000);
    blank_lz = 0;
  endtask

  task automatic test_back_to_back();
    value = 16'h1111; dash_mask = 4'b0001; load = 1; step();
    value = 16'h9876; dash_mask = 4'b0000; step();
    load = 0;
    for (int i = 0; i < 2 * FRM && m_t % FRM != FRM - 1; i++) step();
    run_checked("wrapload", 2 * FRM, 1, 16'h4321, 4'b0100);
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 2 * FRM && m_t % FRM != 3 * DIV + 3; i++) step();
    enable = 0;
    run_checked("dis", 20, 1, 16'h5A5A, 4'b0000);
    enable = 1;
    step();
    total++; if (frame_start !== 1'b1 || e_frame !== 1'b1) begin bad++;
      $display("FAIL resume_fs got=%b exp=1", frame_start); end
    run_checked("resume", FRM + 8, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * FRM && m_t % FRM != DIV + 5; i++) step();
    total++; if (digit_en_n !== 4'b1101) begin bad++; $display("FAIL rstmid_pre got=%b exp=1101", digit_en_n); end
    #2 rst_n = 0;
    #1;
    total++; if ({digit_en_n, digit_bits, digit_dash, frame_start} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL rstmid_async got=%b/%h/%b/%b exp=1111/0/0/0", digit_en_n, digit_bits, digit_dash, frame_start); end
    model_clear();
    @(negedge clk); rst_n = 1;
    run_checked("rstmid", FRM + 4, 0, '0, '0);
  endtask

  task automatic test_random();
    int off_left;
    off_left = 0;
    for (int i = 0; i < 600; i++) begin
      load = 0;
      if ($urandom_range(0, 15) == 0 || (m_run && m_t % FRM == FRM - 1 && $urandom_range(0, 1) == 1)) begin
        load = 1; value = 16'($urandom);
        if ($urandom_range(0, 3) == 0) value = 16'($urandom_range(0, 15));
        dash_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
      if (off_left > 0) begin off_left--; enable = (off_left == 0); end
      else if ($urandom_range(0, 150) == 0) begin off_left = $urandom_range(1, 12); enable = 0; end
      step();
      total++; if ({digit_en_n, frame_start} !== {e_en, e_frame}) begin bad++;
        $display("FAIL rand_en i=%0d got=%b/%b exp=%b/%b", i, digit_en_n, frame_start, e_en, e_frame); end
      if (e_chk) begin total++; if ({digit_dash, digit_bits} !== {e_dash, e_bits}) begin bad++;
        $display("FAIL rand_bits i=%0d got=%b/%h exp=%b/%h", i, digit_dash, digit_bits, e_dash, e_bits); end end
    end
    load = 0; enable = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_lz();
    test_dash();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
